// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB packet transmitter.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [7:0]   SYNC_BYTE   = 8'h80;
  localparam int unsigned  STUFF_LIMIT = 6;

  // Line levels as {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // NRZI: a 0 toggles J<->K, a 1 holds the level
  function automatic logic [1:0] nrzi_next(input logic [1:0] cur, input logic bit_val);
    return bit_val ? cur : ~cur;
  endfunction

endpackage

// File: rtl/usb_tx_if.sv
// Byte-stream handshake between the packet framer and the USB transmitter.
interface usb_tx_if;
  import usb_tx_pkg::*;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, output tx_last, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, input  tx_last, output tx_ready);

endinterface

// File: rtl/usb_tx_encoder_tx_bit_timer.sv
// Bit-time rollover counter; bit_strobe is high during the last clock of each bit.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic bit_strobe
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;

  // Strobe is registered one count early so it coincides with the wrap cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q      <= '0;
      bit_strobe <= 1'b0;
    end else if (clr) begin
      cnt_q      <= '0;
      bit_strobe <= 1'b0;
    end else if (en) begin
      cnt_q      <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      bit_strobe <= (cnt_q == CNT_PRE);
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmitter: SYNC, LSB-first serialisation, bit stuffing,
// NRZI and EOP, with a one-byte holding register ahead of the shifter.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic      clk,
  input  logic      n_rst,
  usb_tx_if.slave   tx,
  output logic      tx_busy,
  output logic      tx_error,
  output logic      d_plus,
  output logic      d_minus
);

  tx_state_t  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       last_taken_q, last_taken_d;
  logic [2:0] ones_q, ones_d;
  logic [1:0] line_q, line_d;
  logic       stuff_end_q, stuff_end_d;
  logic       eop_cnt_q, eop_cnt_d;
  logic       busy_q, busy_d;
  logic       error_q, error_d;
  logic       ready_q, ready_d;

  logic       bit_strobe;
  logic       accept;
  logic       at_boundary;
  logic       stuff_due;
  logic       emit_en;
  logic       emit_bit;
  logic [2:0] nxt_idx;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         (state_q != IDLE),
    .clr        (state_q == IDLE),
    .bit_strobe (bit_strobe)
  );

  assign accept      = tx.tx_valid & ready_q;
  assign stuff_due   = (ones_q == 3'(STUFF_LIMIT));
  assign at_boundary = ((state_q == SYNC || state_q == DATA) && bit_idx_q == 3'd7) ||
                       (state_q == STUFF && stuff_end_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_taken_q <= 1'b0;
      ones_q       <= '0;
      line_q       <= LINE_J;
      stuff_end_q  <= 1'b0;
      eop_cnt_q    <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      last_taken_q <= last_taken_d;
      ones_q       <= ones_d;
      line_q       <= line_d;
      stuff_end_q  <= stuff_end_d;
      eop_cnt_q    <= eop_cnt_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      ready_q      <= ready_d;
    end
  end

  // The state names the bit currently on the line; decisions are made on the strobe
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    last_taken_d = last_taken_q;
    ones_d       = ones_q;
    line_d       = line_q;
    stuff_end_d  = stuff_end_q;
    eop_cnt_d    = eop_cnt_q;
    busy_d       = busy_q;
    error_d      = 1'b0;
    emit_en      = 1'b0;
    emit_bit     = 1'b0;
    nxt_idx      = bit_idx_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SYNC;
          busy_d    = 1'b1;
          shift_d   = SYNC_BYTE;
          bit_idx_d = '0;
          emit_en   = 1'b1;
          emit_bit  = SYNC_BYTE[0];
        end
      end

      SYNC, DATA, STUFF: begin
        if (bit_strobe) begin
          if (stuff_due) begin
            state_d     = STUFF;
            stuff_end_d = (bit_idx_q == 3'd7);
            emit_en     = 1'b1;
            emit_bit    = 1'b0;
          end else if (at_boundary) begin
            if (hold_full_q) begin
              state_d     = DATA;
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              bit_idx_d   = '0;
              emit_en     = 1'b1;
              emit_bit    = hold_q[0];
            end else begin
              // Hold empty: normal end if last was taken, otherwise underrun
              state_d   = EOP_SE0;
              line_d    = LINE_SE0;
              eop_cnt_d = 1'b0;
              error_d   = ~last_taken_q;
            end
          end else begin
            state_d   = (state_q == STUFF) ? DATA : state_q;
            bit_idx_d = nxt_idx;
            emit_en   = 1'b1;
            emit_bit  = shift_q[nxt_idx];
          end
        end
      end

      EOP_SE0: begin
        if (bit_strobe) begin
          if (eop_cnt_q) begin
            state_d = EOP_J;
            line_d  = LINE_J;
          end else begin
            eop_cnt_d = 1'b1;
          end
        end
      end

      EOP_J: begin
        if (bit_strobe) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          last_taken_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    if (emit_en) begin
      line_d = nrzi_next(line_q, emit_bit);
      ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
    end

    // A new byte overrides a same-cycle pull from hold
    if (accept) begin
      hold_d      = tx.tx_data;
      hold_full_d = 1'b1;
      if (tx.tx_last) last_taken_d = 1'b1;
    end

    ready_d = ~hold_full_d & ~last_taken_d & ~(state_d == EOP_SE0 || state_d == EOP_J);
  end

  assign tx.tx_ready         = ready_q;
  assign tx_busy             = busy_q;
  assign tx_error            = error_q;
  assign {d_plus, d_minus}   = line_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: expected line levels per bit time are
// queued at stimulus time and compared by a monitor that decodes each packet.
module tb_usb_tx_encoder;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic tx_busy, tx_error, d_plus, d_minus;

  usb_tx_if tx();

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_error (tx_error),
    .d_plus   (d_plus),
    .d_minus  (d_minus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pkts_seen = 0;
  int exp_total = 0;
  int last_busy = 0;

  logic [1:0] exp_lv[$];
  int         exp_n[$];
  int         exp_err[$];
  logic [7:0] pkt[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: bit list -> stuffing -> NRZI levels, one entry per bit time
  task automatic model_push(input bit has_last);
    int bits[$];
    int sync_v;
    logic [1:0] lvl;
    int ones;
    int n;
    sync_v = 'h80;
    for (int i = 0; i < 8; i++) bits.push_back((sync_v >> i) & 1);
    foreach (pkt[k]) for (int i = 0; i < 8; i++) bits.push_back(int'(pkt[k][i]));
    lvl = 2'b10;
    ones = 0;
    n = 0;
    foreach (bits[j]) begin
      if (bits[j] == 0) begin lvl = ~lvl; ones = 0; end
      else ones++;
      exp_lv.push_back(lvl); n++;
      if (ones == 6) begin
        lvl = ~lvl; ones = 0;
        exp_lv.push_back(lvl); n++;
      end
    end
    exp_lv.push_back(2'b00);
    exp_lv.push_back(2'b00);
    exp_lv.push_back(2'b10);
    exp_n.push_back(n + 3);
    exp_err.push_back(has_last ? -1 : n * CPB);
    exp_total++;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    logic rdy;
    rdy = 1'b0;
    @(negedge clk);
    tx.tx_valid = 1'b1;
    tx.tx_data  = d;
    tx.tx_last  = last;
    for (int t = 0; t < 2000; t++) begin
      rdy = tx.tx_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0h not accepted, expected acceptance", d);
    end
  endtask

  task automatic send_packet(input bit has_last, input bit expect_it);
    if (expect_it) model_push(has_last);
    foreach (pkt[k]) send_byte(pkt[k], has_last && (k == pkt.size() - 1));
    @(negedge clk);
    tx.tx_valid = 1'b0;
    tx.tx_last  = 1'b0;
  endtask

  task automatic wait_pkts(input int target);
    int t;
    t = 0;
    while (pkts_seen < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("packet_completion", pkts_seen, target);
  endtask

  // Monitor: samples mid-bit, counts busy cycles, error pulses and mid-bit changes
  initial begin : monitor
    logic [1:0] obs[$];
    logic [1:0] bit_lvl;
    logic [1:0] e;
    int cyc, errs, err_at, glitches, n, e_err, bad;
    bit in_pkt;
    in_pkt = 1'b0;
    bit_lvl = 2'b10;
    cyc = 0; errs = 0; err_at = -1; glitches = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        in_pkt = 1'b0;
        continue;
      end
      if (!in_pkt && tx_busy) begin
        in_pkt = 1'b1;
        cyc = 0; errs = 0; err_at = -1; glitches = 0;
        obs.delete();
      end
      if (in_pkt && tx_busy) begin
        if (cyc % CPB == 0) bit_lvl = {d_plus, d_minus};
        else if ({d_plus, d_minus} != bit_lvl) glitches++;
        if (cyc % CPB == CPB / 2) obs.push_back(bit_lvl);
        if (tx_error) begin errs++; err_at = cyc; end
        cyc++;
      end else if (in_pkt) begin
        in_pkt = 1'b0;
        if (exp_n.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_packet: got %0d bit times, expected no packet", obs.size());
        end else begin
          n = exp_n.pop_front();
          e_err = exp_err.pop_front();
          bad = 0;
          for (int i = 0; i < n; i++) begin
            e = exp_lv.pop_front();
            if (i >= obs.size()) bad++;
            else if (obs[i] != e) bad++;
          end
          check("bit_times", obs.size(), n);
          check("line_level_mismatches", bad, 0);
          check("busy_cycles", cyc, n * CPB);
          check("mid_bit_changes", glitches, 0);
          check("error_pulses", errs, (e_err < 0) ? 0 : 1);
          if (e_err >= 0) check("error_cycle", err_at, e_err);
        end
        last_busy = cyc;
        pkts_seen++;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int changes;
    int len;
    int gap;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    tx.tx_last  = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_d_plus", int'(d_plus), 1);
    check("rst_d_minus", int'(d_minus), 0);
    check("rst_tx_ready", int'(tx.tx_ready), 1);
    check("rst_tx_busy", int'(tx_busy), 0);
    check("rst_tx_error", int'(tx_error), 0);

    n_rst = 1'b1;
    changes = 0;
    repeat (50) begin
      @(negedge clk);
      if ({d_plus, d_minus, tx_busy, tx_error, tx.tx_ready} != 5'b10001) changes++;
    end
    check("idle_outputs_stable", changes, 0);

    pkt.delete(); pkt.push_back(8'h00);
    send_packet(1'b1, 1'b1);
    wait_pkts(exp_total);
    check("busy_len_00", last_busy, 152);

    pkt.delete(); pkt.push_back(8'hFF);
    send_packet(1'b1, 1'b1);
    wait_pkts(exp_total);
    check("busy_len_ff", last_busy, 160);

    pkt.delete(); pkt.push_back(8'hA5); pkt.push_back(8'h3C);
    send_packet(1'b1, 1'b1);
    wait_pkts(exp_total);
    check("busy_len_a5_3c", last_busy, 27 * CPB);

    pkt.delete(); pkt.push_back(8'h12);
    send_packet(1'b0, 1'b1);
    wait_pkts(exp_total);
    check("busy_len_underrun", last_busy, 19 * CPB);

    // Reset in the middle of the first data byte of a two-byte packet
    pkt.delete(); pkt.push_back(8'hA5); pkt.push_back(8'h3C);
    send_packet(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("abort_busy_before_reset", int'(tx_busy), 1);
    #2 n_rst = 1'b0;
    #1;
    check("abort_d_plus", int'(d_plus), 1);
    check("abort_d_minus", int'(d_minus), 0);
    check("abort_tx_busy", int'(tx_busy), 0);
    check("abort_tx_ready", int'(tx.tx_ready), 1);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    pkt.delete(); pkt.push_back(8'h5A);
    send_packet(1'b1, 1'b1);
    wait_pkts(exp_total);

    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, 3);
      pkt.delete();
      for (int k = 0; k < len; k++)
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      send_packet(1'b1, 1'b1);
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
    end
    wait_pkts(exp_total);
    check("expected_queue_drained", exp_n.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
